ksa_addsub_pipe: RTL and testbench

- Pipelined 16-bit Kogge-Stone adder/subtractor with a valid/ready handshake on both sides.
- Computes x+y+cin (add) or x-y-bin (subtract), returning carry/borrow out and signed overflow.
- Serves datapath blocks that need subtraction alongside the existing combinational KoggeStoneAdder.
- Registered prefix tree; throughput of one operation per clock.

---
 rtl/ksa_pkg.sv | 25 ++
 rtl/ksa_prefix_row.sv | 31 +++
 rtl/ksa_addsub_pipe.sv | 140 ++++++++++++++
 tb/tb_ksa_addsub_pipe.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ksa_pkg.sv
`default_nettype none
// ============================================================================
// ksa_pkg : shared constants and helpers for the Kogge-Stone add/sub pipeline
// Rev 1.0 : initial release
// ============================================================================
package ksa_pkg;

   localparam int   KSA_WIDTH = 16;
   localparam logic OP_ADD    = 1'b0;
   localparam logic OP_SUB    = 1'b1;

   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ksa_prefix_row.sv
`default_nettype none
// ============================================================================
// ksa_prefix_row : one combinational row of Kogge-Stone black/grey cells
// Rev 1.0 : initial release
// ============================================================================
module ksa_prefix_row
   import ksa_pkg::*;
#(
   parameter int WIDTH = KSA_WIDTH,
   parameter int DIST  = 1
) (
   input  logic [WIDTH-1:0] g_i,
   input  logic [WIDTH-1:0] p_i,
   output logic [WIDTH-1:0] g_o,
   output logic [WIDTH-1:0] p_o
);

   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
         if (i < DIST) begin : g_pass
            assign g_o[i] = g_i[i];
            assign p_o[i] = p_i[i];
         end else begin : g_cell
            assign g_o[i] = g_i[i] | (p_i[i] & g_i[i-DIST]);
            assign p_o[i] = p_i[i] & p_i[i-DIST];
         end
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/ksa_addsub_pipe.sv
`default_nettype none
// ============================================================================
// ksa_addsub_pipe : 3-stage pipelined Kogge-Stone adder/subtractor, valid/ready
// Rev 1.0 : initial release
// ============================================================================
module ksa_addsub_pipe
   import ksa_pkg::*;
#(
   parameter int WIDTH = KSA_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             sub,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             ovf
);

   localparam int LEVELS = clog2(WIDTH);
   localparam int SPLIT  = LEVELS / 2;

   logic [WIDTH-1:0] w_ye;
   logic             w_c0;
   logic [WIDTH-1:0] w_p;
   logic [WIDTH-1:0] w_g0;
   logic [WIDTH-1:0] w_g_lvl [0:LEVELS];
   logic [WIDTH-1:0] w_p_lvl [0:LEVELS];

   logic [WIDTH-1:0] s1_g_q, s1_pg_q, s1_p_q;
   logic             s1_c0_q, s1_sub_q, s1_v_q, s1_v_d;
   logic [WIDTH-1:0] s2_g_q, s2_p_q;
   logic             s2_c0_q, s2_sub_q, s2_v_q, s2_v_d;
   logic [WIDTH-1:0] out_res_q;
   logic             out_cout_q, out_ovf_q, out_v_q, out_v_d;

   logic             w_load1, w_load2, w_load3, w_accept;
   logic [WIDTH-1:0] w_c, w_res;
   logic             w_cout, w_ovf;

   // Subtraction is x + ~y + ~bin; the carry-in is folded into bit 0's generate.
   assign w_ye = (sub == OP_SUB) ? ~y : y;
   assign w_c0 = (sub == OP_SUB) ? ~cin : cin;
   assign w_p  = x ^ w_ye;
   assign w_g0 = x & w_ye;
   assign w_g_lvl[0] = {w_g0[WIDTH-1:1], w_g0[0] | (w_p[0] & w_c0)};
   assign w_p_lvl[0] = w_p;

   generate
      for (genvar k = 0; k < LEVELS; k++) begin : g_row
         if (k == SPLIT) begin : g_from_s1
            ksa_prefix_row #(.WIDTH(WIDTH), .DIST(1 << k)) u_row (
               .g_i (s1_g_q),
               .p_i (s1_pg_q),
               .g_o (w_g_lvl[k+1]),
               .p_o (w_p_lvl[k+1])
            );
         end else begin : g_chain
            ksa_prefix_row #(.WIDTH(WIDTH), .DIST(1 << k)) u_row (
               .g_i (w_g_lvl[k]),
               .p_i (w_p_lvl[k]),
               .g_o (w_g_lvl[k+1]),
               .p_o (w_p_lvl[k+1])
            );
         end
      end
   endgenerate

   assign w_c    = {s2_g_q[WIDTH-2:0], s2_c0_q};
   assign w_res  = s2_p_q ^ w_c;
   assign w_cout = (s2_sub_q == OP_SUB) ? ~s2_g_q[WIDTH-1] : s2_g_q[WIDTH-1];
   assign w_ovf  = s2_g_q[WIDTH-1] ^ w_c[WIDTH-1];

   // Each stage may load when empty or when its successor loads this cycle.
   always_comb begin
      w_load3  = ~out_v_q | out_ready;
      w_load2  = ~s2_v_q | w_load3;
      w_load1  = ~s1_v_q | w_load2;
      in_ready = w_load1 & ~reset;
      w_accept = in_valid & in_ready;
      s1_v_d   = w_load1 ? w_accept : s1_v_q;
      s2_v_d   = w_load2 ? s1_v_q   : s2_v_q;
      out_v_d  = w_load3 ? s2_v_q   : out_v_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_v_q     <= 1'b0;
         s2_v_q     <= 1'b0;
         out_v_q    <= 1'b0;
         s1_g_q     <= '0;
         s1_pg_q    <= '0;
         s1_p_q     <= '0;
         s1_c0_q    <= 1'b0;
         s1_sub_q   <= 1'b0;
         s2_g_q     <= '0;
         s2_p_q     <= '0;
         s2_c0_q    <= 1'b0;
         s2_sub_q   <= 1'b0;
         out_res_q  <= '0;
         out_cout_q <= 1'b0;
         out_ovf_q  <= 1'b0;
      end else begin
         s1_v_q  <= s1_v_d;
         s2_v_q  <= s2_v_d;
         out_v_q <= out_v_d;
         if (w_load1 && w_accept) begin
            s1_g_q   <= w_g_lvl[SPLIT];
            s1_pg_q  <= w_p_lvl[SPLIT];
            s1_p_q   <= w_p;
            s1_c0_q  <= w_c0;
            s1_sub_q <= sub;
         end
         if (w_load2 && s1_v_q) begin
            s2_g_q   <= w_g_lvl[LEVELS];
            s2_p_q   <= s1_p_q;
            s2_c0_q  <= s1_c0_q;
            s2_sub_q <= s1_sub_q;
         end
         if (w_load3 && s2_v_q) begin
            out_res_q  <= w_res;
            out_cout_q <= w_cout;
            out_ovf_q  <= w_ovf;
         end
      end
   end

   assign out_valid = out_v_q;
   assign result    = out_res_q;
   assign cout      = out_cout_q;
   assign ovf       = out_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_ksa_addsub_pipe.sv
`default_nettype none
// ============================================================================
// tb_ksa_addsub_pipe : table vectors, stall/reset sequences and sweep with scoreboard
// Rev 1.0 : initial release
// ============================================================================
module tb_ksa_addsub_pipe;
   import ksa_pkg::*;

   typedef struct packed {
      logic [15:0] r;
      logic        co;
      logic        ov;
   } exp_t;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        s;
      logic        c;
      exp_t        e;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] x, y;
   logic        sub, cin;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] result;
   logic        cout, ovf;

   logic rand_rdy, rdy_force, rnd_bit;
   assign out_ready = rand_rdy ? rnd_bit : rdy_force;

   exp_t sb[$];
   vec_t vecs [0:7];
   int   n_cmp  = 0;
   int   n_fail = 0;
   int   n_sent = 0;
   int   n_recv = 0;

   ksa_addsub_pipe #(.WIDTH(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .y         (y),
      .sub       (sub),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .cout      (cout),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   initial rnd_bit = 1'b1;
   always begin
      @(posedge clk);
      #1;
      rnd_bit = ($urandom_range(0, 3) != 0);
   end

   function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                  input logic s, input logic c);
      logic [16:0] full;
      exp_t        e;
      if (s == OP_SUB) begin
         full = {1'b0, a} - {1'b0, b} - {16'd0, c};
         e.ov = (a[15] != b[15]) && (full[15] != a[15]);
      end else begin
         full = {1'b0, a} + {1'b0, b} + {16'd0, c};
         e.ov = (a[15] == b[15]) && (full[15] != a[15]);
      end
      e.r  = full[15:0];
      e.co = full[16];
      return e;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_output: got result %h, required no output", result);
         end else begin
            e = sb.pop_front();
            n_recv++;
            check("out_result", {16'd0, result}, {16'd0, e.r});
            check("out_cout", {31'd0, cout}, {31'd0, e.co});
            check("out_ovf", {31'd0, ovf}, {31'd0, e.ov});
         end
      end
   end

   task automatic send(input logic [15:0] a, input logic [15:0] b,
                       input logic s, input logic c, input exp_t e);
      bit done;
      done     = 1'b0;
      in_valid = 1'b1;
      x = a; y = b; sub = s; cin = c;
      for (int t = 0; t < 200 && !done; t++) begin
         @(negedge clk);
         if (in_ready) begin
            sb.push_back(e);
            n_sent++;
            done = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!done) begin
         n_cmp++;
         n_fail++;
         $display("FAIL send_timeout: got in_ready 0 for 200 cycles, required 1");
      end
   endtask

   task automatic drain();
      for (int t = 0; t < 200 && sb.size() != 0; t++) begin
         @(posedge clk);
         #1;
      end
      check("drain_empty", sb.size(), 0);
   endtask

   initial begin : stim
      int   lat;
      bit   seen;
      exp_t e;
      vecs[0] = '{16'd1000,  16'd2000,  OP_ADD, 1'b1, '{16'd3001,  1'b0, 1'b0}};
      vecs[1] = '{16'd5000,  16'd1000,  OP_SUB, 1'b0, '{16'd4000,  1'b0, 1'b0}};
      vecs[2] = '{16'd1000,  16'd2000,  OP_SUB, 1'b0, '{16'hFC18,  1'b1, 1'b0}};
      vecs[3] = '{16'hFFFF,  16'h0001,  OP_ADD, 1'b0, '{16'h0000,  1'b1, 1'b0}};
      vecs[4] = '{16'h7FFF,  16'h0001,  OP_ADD, 1'b0, '{16'h8000,  1'b0, 1'b1}};
      vecs[5] = '{16'h8000,  16'h0001,  OP_SUB, 1'b0, '{16'h7FFF,  1'b0, 1'b1}};
      vecs[6] = '{16'h0000,  16'h0001,  OP_SUB, 1'b0, '{16'hFFFF,  1'b1, 1'b0}};
      vecs[7] = '{16'h8000,  16'h8000,  OP_ADD, 1'b0, '{16'h0000,  1'b1, 1'b1}};

      reset = 1'b1; in_valid = 1'b0; x = '0; y = '0; sub = 1'b0; cin = 1'b0;
      rand_rdy = 1'b0; rdy_force = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", {31'd0, out_valid}, 0);
      check("rst_result", {16'd0, result}, 0);
      check("rst_cout", {31'd0, cout}, 0);
      check("rst_ovf", {31'd0, ovf}, 0);
      reset = 1'b0;
      @(negedge clk);
      check("rst_in_ready", {31'd0, in_ready}, 1);
      @(posedge clk);
      #1;

      // Latency: accept edge counts as 1, out_valid must follow the 3rd edge.
      send(vecs[0].a, vecs[0].b, vecs[0].s, vecs[0].c, vecs[0].e);
      lat = 1; seen = 1'b0;
      for (int t = 0; t < 10 && !seen; t++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
         else begin
            @(posedge clk);
            #1;
            lat++;
         end
      end
      check("latency", lat, 3);
      @(posedge clk);
      #1;

      for (int i = 1; i < 8; i++)
         send(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].c, vecs[i].e);
      drain();

      // Backpressure: fill the pipe with out_ready low, then release.
      rdy_force = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         x = 16'(i * 1111 + 7); y = 16'(i * 333 + 1); sub = 1'b0; cin = 1'b0;
         @(negedge clk);
         check("bp_accept", {31'd0, in_ready}, 1);
         if (in_ready) begin
            sb.push_back(model(x, y, sub, cin));
            n_sent++;
         end
         @(posedge clk);
         #1;
      end
      x = 16'd4444; y = 16'd5555; sub = 1'b1; cin = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("bp_in_ready_low", {31'd0, in_ready}, 0);
         check("bp_out_valid", {31'd0, out_valid}, 1);
         if (sb.size() != 0) check("bp_result_stable", {16'd0, result}, {16'd0, sb[0].r});
         @(posedge clk);
         #1;
      end
      rdy_force = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i == 0) begin
            check("bp_reaccept", {31'd0, in_ready}, 1);
            if (in_ready) begin
               sb.push_back(model(x, y, sub, cin));
               n_sent++;
            end
         end
         check("bp_stream", {31'd0, out_valid}, 1);
         @(posedge clk);
         #1;
         in_valid = 1'b0;
      end
      drain();

      // Reset with two beats in flight: both discarded.
      send(16'd12, 16'd34, OP_ADD, 1'b0, model(16'd12, 16'd34, OP_ADD, 1'b0));
      send(16'd56, 16'd78, OP_SUB, 1'b0, model(16'd56, 16'd78, OP_SUB, 1'b0));
      reset = 1'b1;
      #1;
      check("midrst_out_valid", {31'd0, out_valid}, 0);
      n_sent = n_sent - sb.size();
      sb.delete();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("midrst_no_stale", {31'd0, out_valid}, 0);
      end
      @(posedge clk);
      #1;
      e = model(16'd999, 16'd1, OP_ADD, 1'b0);
      send(16'd999, 16'd1, OP_ADD, 1'b0, e);
      drain();

      rand_rdy = 1'b1;
      for (int xi = 0; xi <= 65; xi++)
         for (int yi = 0; yi <= 65; yi++)
            for (int s = 0; s < 2; s++)
               for (int c = 0; c < 2; c++)
                  send(16'(xi * 1000), 16'(yi * 1000), s[0], c[0],
                       model(16'(xi * 1000), 16'(yi * 1000), s[0], c[0]));
      drain();
      rand_rdy = 1'b0;

      check("returned_once", n_recv, n_sent);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
